// File: rtl/pkt_receiver_mp.sv
// Multi-port packet receiver: round-robin grant, pre-read delay, hold register and a {port,last,data} FIFO.
// Optional macro PKT_RECV_RANDOM_DELAY_EN replaces the fixed pre-read delay with an LFSR-driven one.
module pkt_receiver_mp #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_DELAY = 5,
  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        ready,
  input  logic [NUM_PORTS*DATA_W-1:0] data,
  output logic [NUM_PORTS-1:0]        read,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [PORT_W-1:0]           out_port,
  output logic                        out_last,
  output logic                        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PORT_W + 1 + DATA_W;

  typedef enum logic [2:0] {IDLE, ARB, WAIT, READ, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [PORT_W-1:0] sel, sel_nxt, last_grant, last_grant_nxt, pick;
  logic              pick_ok;
  logic [3:0]        dly, dly_nxt, dly_load;
  logic              hold_vld, hold_vld_nxt;
  logic [DATA_W-1:0] hold_data, sel_data;
  logic              sel_ready;
  logic              cap, push, push_last, pop;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              full, empty;

  // Round-robin: the nearest requester above last_grant wins, so scan from farthest to nearest.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (ready[PORT_W'((int'(last_grant) + i) % NUM_PORTS)]) begin
        pick    = PORT_W'((int'(last_grant) + i) % NUM_PORTS);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_ready = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel == PORT_W'(p)) begin
        sel_data  = data[p*DATA_W +: DATA_W];
        sel_ready = ready[p];
      end
    end
  end

`ifdef PKT_RECV_RANDOM_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr <= 8'hA5;
    else if (state == ARB && pick_ok)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign dly_load = 4'(1 + (int'(lfsr) % MAX_DELAY));
`else
  assign dly_load = 4'(MAX_DELAY - 1);
`endif

  // WAIT lasts exactly dly_load cycles (at least one).
  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    dly_nxt        = dly;
    hold_vld_nxt   = hold_vld;
    read           = '0;
    cap            = 1'b0;
    push           = 1'b0;
    push_last      = 1'b0;
    case (state)
      IDLE: if (|ready) state_nxt = ARB;
      ARB: begin
        if (pick_ok) begin
          sel_nxt   = pick;
          dly_nxt   = dly_load;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (dly != 4'd0) dly_nxt = dly - 4'd1;
        if (dly <= 4'd1) state_nxt = READ;
      end
      READ: begin
        if (!sel_ready) begin
          state_nxt = FLUSH;
        end else if (!full) begin
          read[sel]    = 1'b1;
          cap          = 1'b1;
          push         = hold_vld;
          hold_vld_nxt = 1'b1;
        end
      end
      FLUSH: begin
        if (!hold_vld || !full) begin
          push           = hold_vld;
          push_last      = hold_vld;
          hold_vld_nxt   = 1'b0;
          last_grant_nxt = sel;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      dly        <= '0;
      hold_vld   <= 1'b0;
      hold_data  <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      dly        <= dly_nxt;
      hold_vld   <= hold_vld_nxt;
      if (cap) hold_data <= sel_data;
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {sel, push_last, hold_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry is masked while empty so stale memory never reaches the outputs.
  assign out_valid                      = !empty;
  assign {out_port, out_last, out_data} = empty ? '0 : mem[rptr];
  assign busy                           = (state != IDLE);

endmodule

// File: tb/tb_pkt_receiver_mp.sv
// Scoreboard bench for pkt_receiver_mp: behavioural port sources, per-port expected queues, grant-order checks.
// Wait-length expectations follow PKT_RECV_RANDOM_DELAY_EN when that macro is defined.
module tb_pkt_receiver_mp;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXD  = 5;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] ready = '0;
  logic [NP*DW-1:0] data = '0;
  logic [NP-1:0] read;
  logic          out_valid, out_last, busy;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_port;

  pkt_receiver_mp #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .MAX_DELAY(MAXD)) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .data(data), .read(read),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_port(out_port), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int port; int data; bit last; } word_t;
  word_t expQ[$];
  int    orderQ[$];
  int    total = 0;
  int    bad = 0;
  int    lf = 8'hA5;

  int            srcLen[NP], srcIdx[NP], srcHold[NP], srcGap[NP];
  bit            srcActive[NP];
  int            srcData[NP][32];
  logic [NP-1:0] fire;
  bit            inPkt = 0;
  int            curPort = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A source presents its packet bytes in order, advancing on every read&ready edge, then drops ready.
  initial begin
    for (int p = 0; p < NP; p++) begin
      srcLen[p] = 0; srcIdx[p] = 0; srcHold[p] = 0; srcActive[p] = 0; srcGap[p] = 10;
    end
    forever begin
      @(negedge clk);
      fire = read & ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (fire[p]) srcIdx[p]++;
        if (srcActive[p]) begin
          if (srcLen[p] == 0) begin
            if (srcHold[p] <= 1) srcActive[p] = 0;
            else srcHold[p]--;
          end else if (srcIdx[p] >= srcLen[p]) begin
            srcActive[p] = 0;
          end
          srcGap[p] = 0;
        end else begin
          srcGap[p]++;
        end
        ready[p] = srcActive[p];
        data[p*DW +: DW] = (srcActive[p] && srcIdx[p] < srcLen[p]) ? DW'(srcData[p][srcIdx[p]]) : '0;
      end
    end
  end

  task automatic applyStimulus(input int p, input int len, input int seed);
    word_t w;
    for (int i = 0; i < len; i++) begin
      srcData[p][i] = (seed < 0) ? int'($urandom_range(0, 255)) : seed * (i + 1);
      w.port = p;
      w.data = srcData[p][i];
      w.last = (i == len - 1);
      expQ.push_back(w);
    end
    srcLen[p] = len; srcIdx[p] = 0; srcHold[p] = 3; srcActive[p] = 1;
  endtask

  task automatic checkOutput();
    int idx;
    idx = -1;
    if (inPkt) check("contiguous_port", int'(out_port), curPort);
    else if (orderQ.size() > 0) check("grant_order", int'(out_port), orderQ.pop_front());
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].port == int'(out_port)) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_word: got port %0d data %0d, expected no word", out_port, out_data);
    end else begin
      check("out_data", int'(out_data), expQ[idx].data);
      check("out_last", int'(out_last), int'(expQ[idx].last));
      expQ.delete(idx);
    end
    inPkt   = !out_last;
    curPort = int'(out_port);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) checkOutput();
    end
  end

  function automatic bit anyActive();
    bit a;
    a = 0;
    for (int p = 0; p < NP; p++) a |= srcActive[p];
    return a;
  endfunction

  function automatic int nextWait();
    int w;
`ifdef PKT_RECV_RANDOM_DELAY_EN
    w  = 1 + (lf % MAXD);
    lf = ((lf << 1) | (((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1)) & 8'hFF;
`else
    w = MAXD - 1;
`endif
    return w;
  endfunction

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || out_valid || expQ.size() != 0 || anyActive()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // Cycles from the first cycle ready[p] is seen high to the first cycle read[p] is high.
  task automatic measureLatency(input string name, input int p, input int expLat);
    int n;
    n = 0;
    @(negedge clk);
    for (int k = 0; k < 5 && !ready[p]; k++) @(negedge clk);
    while (!read[p] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, n, expLat);
  endtask

  task automatic setOutReady(input bit v);
    @(posedge clk);
    #2;
    out_ready = v;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_read", int'(read), 0);
    check("reset_out_data", int'(out_data), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] pre-read delay over consecutive grants");
    for (int g = 0; g < 8; g++) begin
      applyStimulus(1, 1, -1);
      measureLatency("wait_len", 1, 2 + nextWait());
      waitIdle("latency", 100);
    end

    $display("[TB] three-byte packet on port 2");
    orderQ.push_back(2);
    applyStimulus(2, 3, 11);
    measureLatency("read_latency_p2", 2, 2 + nextWait());
    waitIdle("p2_packet", 100);
    check("busy_after_flush", int'(busy), 0);

    $display("[TB] empty packet advances last_grant");
    applyStimulus(0, 0, -1);
    waitIdle("empty_pkt", 100);
    check("empty_no_output", int'(out_valid), 0);
    orderQ.push_back(1);
    orderQ.push_back(0);
    applyStimulus(0, 2, -1);
    applyStimulus(1, 2, -1);
    waitIdle("after_empty", 200);

    $display("[TB] backpressure on a full buffer");
    setOutReady(0);
    orderQ.push_back(3);
    applyStimulus(3, 10, -1);
    repeat (40) @(negedge clk);
    check("bytes_before_stall", srcIdx[3], DEPTH + 1);
    check("read_when_full", int'(read), 0);
    check("valid_when_full", int'(out_valid), 1);
    setOutReady(1);
    waitIdle("full_drain", 200);

    $display("[TB] reset in the middle of a packet");
    setOutReady(0);
    applyStimulus(2, 10, -1);
    n = 0;
    while (srcIdx[2] < 4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("buffered_before_reset", int'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_out_valid", int'(out_valid), 0);
    check("reset_mid_read", int'(read), 0);
    check("reset_mid_busy", int'(busy), 0);
    for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].port == 2) expQ.delete(i);
    srcActive[2] = 0;
    srcLen[2]    = 0;
    inPkt        = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    setOutReady(1);
    @(negedge clk);
    orderQ.push_back(0);
    orderQ.push_back(3);
    applyStimulus(0, 3, -1);
    applyStimulus(3, 4, -1);
    waitIdle("after_reset", 200);
    orderQ.push_back(0);
    orderQ.push_back(1);
    applyStimulus(0, 2, -1);
    applyStimulus(1, 2, -1);
    waitIdle("rr_after", 200);

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++)
        if (!srcActive[p] && srcGap[p] >= 2 && $urandom_range(0, 15) == 0)
          applyStimulus(p, int'($urandom_range(1, 6)), -1);
    end
    setOutReady(1);
    waitIdle("random_drain", 3000);
    check("leftover_words", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
